// File: rtl/ysyx_041461_wb_pkg.sv
// Shared encodings for the WB commit stage: control and trap codes, CSR map,
// mstatus field positions and reset constants.
package ysyx_041461_wb_pkg;

    typedef enum logic [3:0] {
        TRAP_NOP    = 4'd0,
        TRAP_ECALL  = 4'd1,
        TRAP_MRET   = 4'd2,
        TRAP_EBREAK = 4'd3
    } trap_e;

    typedef enum logic [3:0] {
        WB_NOP    = 4'd0,
        WB_EXE    = 4'd1,
        WB_MEM    = 4'd2,
        WB_IMM    = 4'd3,
        WB_CSRRW  = 4'd4,
        WB_CSRRS  = 4'd5,
        WB_CSRRC  = 4'd6,
        WB_CSRRWI = 4'd7,
        WB_CSRRSI = 4'd8,
        WB_CSRRCI = 4'd9
    } wb_ctrl_e;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] MSTATUS_RST    = 64'h1800;
    localparam logic [63:0] COMMIT_PC_RST  = 64'h3000_0000;
    localparam logic [4:0]  GPR_A0         = 5'd10;

    function automatic logic is_csr_op(input wb_ctrl_e c);
        return c inside {WB_CSRRW, WB_CSRRS, WB_CSRRC, WB_CSRRWI, WB_CSRRSI, WB_CSRRCI};
    endfunction

    // Register forms take their operand from gpr[rs1]; the *I forms use zimm.
    function automatic logic csr_src_is_reg(input wb_ctrl_e c);
        return c inside {WB_CSRRW, WB_CSRRS, WB_CSRRC};
    endfunction

endpackage

// File: rtl/ysyx_041461_gpr_file.sv
// 32x64 integer register file: one write port, two ID read ports with optional
// write-through, plus an unbypassed CSR-source port and a direct x10 tap.
module ysyx_041461_gpr_file #(
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [63:0] wdata,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [63:0] rdata1,
    output logic [63:0] rdata2,
    input  logic [4:0]  src_raddr,
    output logic [63:0] src_rdata,
    output logic [63:0] x10_rdata
);

    logic [63:0] regs [32];

    // NOTE: the array sits on the async reset because every GPR must read 0 after rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 :
                    (RF_BYPASS && we && raddr1 == waddr) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 :
                    (RF_BYPASS && we && raddr2 == waddr) ? wdata : regs[raddr2];

    // The CSR operand belongs to the instruction doing the write, so it sees the old value.
    assign src_rdata = (src_raddr == 5'd0) ? '0 : regs[src_raddr];
    assign x10_rdata = regs[10];

endmodule

// File: rtl/ysyx_041461_wb_commit.sv
// WB commit stage: retires one instruction per cycle into the GPR file and M-mode
// CSRs, handles ecall/mret/ebreak and reports commit/redirect events.
module ysyx_041461_wb_commit
    import ysyx_041461_wb_pkg::*;
#(
    parameter bit RF_BYPASS  = 1'b1,
    parameter bit EBREAK_HLT = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [3:0]  wb_trap,
    input  logic [63:0] wb_exe,
    input  logic [63:0] wb_mem,
    input  logic [4:0]  wb_rd,
    input  logic [4:0]  wb_rs1,
    input  logic [11:0] wb_csr,
    input  logic [63:0] wb_imm,
    input  logic [63:0] wb_zimm,
    input  logic [63:0] wb_pc,
    input  logic [3:0]  wb_ctrl,
    input  logic [31:0] wb_inst,
    input  logic [4:0]  rf_raddr1,
    input  logic [4:0]  rf_raddr2,
    output logic [63:0] rf_rdata1,
    output logic [63:0] rf_rdata2,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        commit_valid,
    output logic [63:0] commit_pc,
    output logic [31:0] commit_inst,
    output logic        halt,
    output logic [63:0] halt_code
);

    wb_ctrl_e    ctrl;
    trap_e       trap;
    logic        live;
    logic        is_ecall, is_mret, is_ebreak;

    logic [63:0] mstatus, mtvec, mepc, mcause, mcycle, minstret;
    logic [63:0] mstatus_n, mtvec_n, mepc_n, mcause_n, mcycle_n, minstret_n;

    logic        gpr_sel, gpr_we;
    logic [63:0] gpr_wdata, gpr_src, gpr_x10, x10_now;
    logic [63:0] csr_old, csr_src, csr_new;
    logic        csr_wr;

    assign ctrl      = wb_ctrl_e'(wb_ctrl);
    assign trap      = trap_e'(wb_trap);
    assign live      = wb_valid && !halt;
    assign is_ecall  = live && trap == TRAP_ECALL;
    assign is_mret   = live && trap == TRAP_MRET;
    assign is_ebreak = live && trap == TRAP_EBREAK && EBREAK_HLT;

    ysyx_041461_gpr_file #(.RF_BYPASS(RF_BYPASS)) u_gpr (
        .clk       (clk),
        .rst       (rst),
        .we        (gpr_we),
        .waddr     (wb_rd),
        .wdata     (gpr_wdata),
        .raddr1    (rf_raddr1),
        .raddr2    (rf_raddr2),
        .rdata1    (rf_rdata1),
        .rdata2    (rf_rdata2),
        .src_raddr (wb_rs1),
        .src_rdata (gpr_src),
        .x10_rdata (gpr_x10)
    );

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        csr_old = '0;
        case (wb_csr)
            CSR_MSTATUS:  csr_old = mstatus;
            CSR_MTVEC:    csr_old = mtvec;
            CSR_MEPC:     csr_old = mepc;
            CSR_MCAUSE:   csr_old = mcause;
            CSR_MCYCLE:   csr_old = mcycle;
            CSR_MINSTRET: csr_old = minstret;
            default:      csr_old = '0;
        endcase
    end

    assign csr_src = csr_src_is_reg(ctrl) ? gpr_src : wb_zimm;

    always_comb begin
        csr_new = csr_src;
        case (ctrl)
            WB_CSRRS, WB_CSRRSI: csr_new = csr_old | csr_src;
            WB_CSRRC, WB_CSRRCI: csr_new = csr_old & ~csr_src;
            default:             csr_new = csr_src;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not touch the CSR.
    assign csr_wr = live && is_csr_op(ctrl) &&
                    (ctrl inside {WB_CSRRW, WB_CSRRWI} || csr_src != '0);

    always_comb begin
        gpr_sel   = 1'b1;
        gpr_wdata = '0;
        case (ctrl)
            WB_EXE: gpr_wdata = wb_exe;
            WB_MEM: gpr_wdata = wb_mem;
            WB_IMM: gpr_wdata = wb_imm;
            WB_CSRRW, WB_CSRRS, WB_CSRRC,
            WB_CSRRWI, WB_CSRRSI, WB_CSRRCI: gpr_wdata = csr_old;
            default: gpr_sel = 1'b0;
        endcase
    end

    assign gpr_we  = live && gpr_sel && wb_rd != 5'd0;
    assign x10_now = (gpr_we && wb_rd == GPR_A0) ? gpr_wdata : gpr_x10;

    // CSR writes first, then trap updates overwrite the fields they own.
    always_comb begin
        mstatus_n  = mstatus;
        mtvec_n    = mtvec;
        mepc_n     = mepc;
        mcause_n   = mcause;
        mcycle_n   = mcycle + 64'd1;
        minstret_n = minstret + {63'd0, live};
        if (csr_wr) begin
            case (wb_csr)
                CSR_MSTATUS:  mstatus_n  = csr_new;
                CSR_MTVEC:    mtvec_n    = csr_new;
                CSR_MEPC:     mepc_n     = csr_new;
                CSR_MCAUSE:   mcause_n   = csr_new;
                CSR_MCYCLE:   mcycle_n   = csr_new;
                CSR_MINSTRET: minstret_n = csr_new;
                default:      ;
            endcase
        end
        if (is_ecall) begin
            mepc_n                                    = wb_pc;
            mcause_n                                  = MCAUSE_ECALL_M;
            mstatus_n[MSTATUS_MPIE]                   = mstatus[MSTATUS_MIE];
            mstatus_n[MSTATUS_MIE]                    = 1'b0;
            mstatus_n[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
        end else if (is_mret) begin
            mstatus_n[MSTATUS_MIE]  = mstatus[MSTATUS_MPIE];
            mstatus_n[MSTATUS_MPIE] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all updates land together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus        <= MSTATUS_RST;
            mtvec          <= '0;
            mepc           <= '0;
            mcause         <= '0;
            mcycle         <= '0;
            minstret       <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            commit_valid   <= 1'b0;
            commit_pc      <= COMMIT_PC_RST;
            commit_inst    <= '0;
            halt           <= 1'b0;
            halt_code      <= '0;
        end else begin
            mstatus        <= mstatus_n;
            mtvec          <= mtvec_n;
            mepc           <= mepc_n;
            mcause         <= mcause_n;
            mcycle         <= mcycle_n;
            minstret       <= minstret_n;
            commit_valid   <= live;
            redirect_valid <= is_ecall || is_mret;
            if (live) begin
                commit_pc   <= wb_pc;
                commit_inst <= wb_inst;
            end
            if (is_ecall)     redirect_pc <= {mtvec[63:2], 2'b00};
            else if (is_mret) redirect_pc <= mepc;
            if (is_ebreak) begin
                halt      <= 1'b1;
                halt_code <= x10_now;
            end
        end
    end

endmodule
